// File: rtl/voltmeter_pkg.sv
// Shared constants, header layout and FSM encoding for the result framing path.
// Pure declarations: no logic, no latency, no flow control.
package voltmeter_pkg;

  localparam int FRAME_BYTES = 5;

  localparam logic [7:0] CMD_CLR_OVF = 8'h01;
  localparam logic [7:0] CMD_FLUSH   = 8'h02;

  localparam int HDR_VALID_BIT = 7;
  localparam int HDR_OVF_BIT   = 6;
  localparam int HDR_LEVEL_MSB = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CLOSE  = 2'd2
  } state_e;

  function automatic logic [7:0] make_hdr(input logic valid, input logic ovf,
                                          input logic [3:0] level);
    logic [7:0] h;
    h                    = 8'h00;
    h[HDR_VALID_BIT]     = valid;
    h[HDR_OVF_BIT]       = ovf;
    h[HDR_LEVEL_MSB:0]   = level;
    return h;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// 32-bit synchronous result FIFO; push/pop/flush act on the clock edge, status is registered.
// Push while full is accepted only together with a pop; flush overrides push and pop.
module result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic [31:0] push_dat_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [3:0]  level_o,
  output logic [31:0] head_dat_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic [31:0]   mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read once count marks them live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign empty_o    = empty_q;
  assign level_o    = 4'(count_q);
  assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/result_framer.sv
// Queues {count,status} results and serves the oldest as a 5-byte SPI frame per chip-select.
// CS edges act 3 cycles late; MISO load strobe is 1 cycle after rx_dv; full FIFO drops captures.
module result_framer
  import voltmeter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        capture_i,
  input  logic [15:0] count_i,
  input  logic [15:0] status_i,
  input  logic        cs_n_i,
  input  logic        rx_dv_i,
  input  logic [7:0]  rx_byte_i,
  output logic        tx_dv_o,
  output logic [7:0]  tx_byte_o,
  output logic        irq_o,
  output logic        overflow_o,
  output logic [3:0]  level_o
);

  state_e      state_q, state_d;
  logic        cs_meta_q, cs_sync_q, cs_prev_q;
  logic [39:0] frame_q, frame_d;
  logic [2:0]  idx_q, idx_d;
  logic        first_q, first_d;
  logic        flush_pend_q, flush_pend_d;
  logic        ovf_q, ovf_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic        fifo_full, fifo_empty;
  logic [3:0]  fifo_level;
  logic [31:0] fifo_head;
  logic        cs_fall, cs_rise;
  logic        close_pop, close_flush, fifo_push, ovf_set, cmd_vld;
  logic [7:0]  hdr, cur_byte;

  assign cs_fall = cs_prev_q & ~cs_sync_q;
  assign cs_rise = ~cs_prev_q & cs_sync_q;
  assign hdr     = make_hdr(~fifo_empty, ovf_q, fifo_level);
  assign cmd_vld = (state_q == ACTIVE) & rx_dv_i & first_q;

  // Only a frame that reached the last byte and carried a valid entry consumes it.
  assign close_pop   = (state_q == CLOSE) && (idx_q == 3'(FRAME_BYTES))
                       && frame_q[32 + HDR_VALID_BIT];
  assign close_flush = (state_q == CLOSE) & flush_pend_q;
  assign fifo_push   = capture_i & ~close_flush;
  assign ovf_set     = fifo_push & fifo_full & ~close_pop;

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (fifo_push),
    .push_dat_i ({count_i, status_i}),
    .pop_i      (close_pop),
    .flush_i    (close_flush),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level),
    .head_dat_o (fifo_head)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
      cs_prev_q <= 1'b1;
    end else begin
      cs_meta_q <= cs_n_i;
      cs_sync_q <= cs_meta_q;
      cs_prev_q <= cs_sync_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = CLOSE;
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd0:    cur_byte = frame_q[39:32];
      3'd1:    cur_byte = frame_q[31:24];
      3'd2:    cur_byte = frame_q[23:16];
      3'd3:    cur_byte = frame_q[15:8];
      3'd4:    cur_byte = frame_q[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      IDLE: begin
        if (cs_sync_q) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = hdr;
        end
      end
      ACTIVE: begin
        if (rx_dv_i) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = cur_byte;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    frame_d      = frame_q;
    idx_d        = idx_q;
    first_d      = first_q;
    flush_pend_d = flush_pend_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          frame_d      = {hdr, fifo_empty ? 32'h0 : fifo_head};
          idx_d        = 3'd1;
          first_d      = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (rx_dv_i) begin
          first_d = 1'b0;
          if (idx_q < 3'(FRAME_BYTES)) idx_d = idx_q + 3'd1;
          if (first_q && rx_byte_i == CMD_FLUSH) flush_pend_d = 1'b1;
        end
      end
      CLOSE: begin
        idx_d        = 3'd0;
        flush_pend_d = 1'b0;
      end
      default: ;
    endcase
    if (ovf_set)                                   ovf_d = 1'b1;
    else if (cmd_vld && rx_byte_i == CMD_CLR_OVF)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_q      <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
    end else begin
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      first_q      <= first_d;
      flush_pend_q <= flush_pend_d;
      ovf_q        <= ovf_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
    end
  end

  assign tx_dv_o    = tx_dv_q;
  assign tx_byte_o  = tx_byte_q;
  assign irq_o      = ~fifo_empty;
  assign overflow_o = ovf_q;
  assign level_o    = fifo_level;

endmodule

// File: tb/tb_result_framer.sv
// Directed bench for result_framer: MISO bytes go through a scoreboard queue checked by a monitor.
module tb_result_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture;
  logic [15:0] count;
  logic [15:0] status;
  logic        cs_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        irq;
  logic        overflow;
  logic [3:0]  level;

  always #5 clk = ~clk;

  result_framer #(.DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .capture_i  (capture),
    .count_i    (count),
    .status_i   (status),
    .cs_n_i     (cs_n),
    .rx_dv_i    (rx_dv),
    .rx_byte_i  (rx_byte),
    .tx_dv_o    (tx_dv),
    .tx_byte_o  (tx_byte),
    .irq_o      (irq),
    .overflow_o (overflow),
    .level_o    (level)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] m_fifo[$];
  logic        m_ovf;
  logic [7:0]  last_hdr;
  logic [39:0] m_frame;
  int          m_idx;
  logic        m_first;
  logic        m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_hdr();
    return {(m_fifo.size() != 0), m_ovf, 2'b00, 4'(m_fifo.size())};
  endfunction

  // In IDLE a header only shows up as a new MISO load when its value changes.
  task automatic push_hdr_if_changed();
    logic [7:0] h;
    h = m_hdr();
    if (h != last_hdr) exp_q.push_back(h);
    last_hdr = h;
  endtask

  task automatic push_hdr_always();
    last_hdr = m_hdr();
    exp_q.push_back(last_hdr);
  endtask

  // Monitor: every new MISO load (rising tx_dv, or changed byte while held) pops one expectation.
  logic       prev_dv = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (tx_dv && (!prev_dv || tx_byte != prev_byte)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx: got 0x%0h, expected no load", tx_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", {24'h0, tx_byte}, {24'h0, mon_exp});
      end
    end
    prev_dv   = tx_dv;
    prev_byte = tx_byte;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_capture(input logic [15:0] c, input logic [15:0] s);
    @(negedge clk);
    capture = 1'b1;
    count   = c;
    status  = s;
    if (m_fifo.size() < 4) m_fifo.push_back({c, s});
    else                   m_ovf = 1'b1;
    push_hdr_if_changed();
    @(negedge clk);
    capture = 1'b0;
    tick(2);
  endtask

  task automatic cs_fall();
    @(negedge clk);
    cs_n    = 1'b0;
    m_frame = {last_hdr, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0};
    m_idx   = 1;
    m_first = 1'b1;
    m_flush = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    exp_q.push_back((m_idx < 5) ? m_frame[(39 - 8*m_idx) -: 8] : 8'h00);
    if (m_idx < 5) m_idx++;
    if (m_first) begin
      if (b == 8'h01) m_ovf = 1'b0;
      if (b == 8'h02) m_flush = 1'b1;
    end
    m_first = 1'b0;
    @(negedge clk);
    rx_dv = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input logic [7:0] cmd);
    send_byte(cmd);
    repeat (4) send_byte(8'h00);
  endtask

  // cap_in_close lands a capture pulse in the single CLOSE cycle (3 edges after CS rises).
  task automatic cs_rise(input logic cap_in_close, input logic [31:0] cd);
    @(negedge clk);
    cs_n = 1'b1;
    if (m_idx == 5 && m_frame[39]) void'(m_fifo.pop_front());
    if (cap_in_close && !m_flush) begin
      if (m_fifo.size() < 4) m_fifo.push_back(cd);
      else                   m_ovf = 1'b1;
    end
    if (m_flush) m_fifo.delete();
    push_hdr_always();
    if (cap_in_close) begin
      tick(3);
      capture = 1'b1;
      count   = cd[31:16];
      status  = cd[15:0];
      @(negedge clk);
      capture = 1'b0;
      tick(3);
    end else begin
      tick(6);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; capture = 1'b0; count = '0; status = '0;
    cs_n = 1'b1; rx_dv = 1'b0; rx_byte = '0;
    m_ovf = 1'b0; last_hdr = 8'h00; m_idx = 0; m_first = 1'b0; m_flush = 1'b0; m_frame = '0;
    tick(2);
    check("rst_tx_dv", {31'h0, tx_dv}, 32'h0);
    check("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_level", {28'h0, level}, 32'h0);
    exp_q.push_back(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    // Single result, plain frame: 81 12 34 80 01.
    do_capture(16'h1234, 16'h8001);
    check("t1_level", {28'h0, level}, 32'd1);
    check("t1_irq", {31'h0, irq}, 32'd1);
    cs_fall();
    send_frame(8'h00);
    cs_rise(1'b0, 32'h0);
    check("t1_level_after", {28'h0, level}, 32'd0);
    check("t1_irq_after", {31'h0, irq}, 32'd0);

    // Overflow on fifth capture, then clear command.
    do_capture(16'h1111, 16'h0001);
    do_capture(16'h2222, 16'h0002);
    do_capture(16'h3333, 16'h0003);
    do_capture(16'h4444, 16'h0004);
    do_capture(16'h5555, 16'h0005);
    check("t2_overflow", {31'h0, overflow}, 32'd1);
    check("t2_level", {28'h0, level}, 32'd4);
    cs_fall();
    send_byte(8'h01);
    check("t2_ovf_cleared", {31'h0, overflow}, 32'd0);
    repeat (4) send_byte(8'h00);
    cs_rise(1'b0, 32'h0);
    check("t2_level_after", {28'h0, level}, 32'd3);

    // Short frame keeps the entry; full retry pops it.
    cs_fall();
    send_byte(8'h00);
    send_byte(8'h00);
    cs_rise(1'b0, 32'h0);
    check("t3_level_abort", {28'h0, level}, 32'd3);
    cs_fall();
    send_frame(8'h00);
    cs_rise(1'b0, 32'h0);
    check("t3_level_retry", {28'h0, level}, 32'd2);

    // Capture coinciding with the CLOSE pop while full.
    do_capture(16'h6666, 16'h0006);
    do_capture(16'h7777, 16'h0007);
    check("t4_level_full", {28'h0, level}, 32'd4);
    cs_fall();
    send_frame(8'h00);
    cs_rise(1'b1, {16'h8888, 16'h0008});
    check("t4_level_after", {28'h0, level}, 32'd4);
    check("t4_overflow", {31'h0, overflow}, 32'd0);

    // Flush command with three entries queued.
    cs_fall();
    send_frame(8'h00);
    cs_rise(1'b0, 32'h0);
    check("t5_level_three", {28'h0, level}, 32'd3);
    cs_fall();
    send_frame(8'h02);
    cs_rise(1'b0, 32'h0);
    check("t5_level_flushed", {28'h0, level}, 32'd0);
    check("t5_irq_flushed", {31'h0, irq}, 32'd0);

    // Reset in the middle of a frame.
    do_capture(16'hABCD, 16'h1357);
    cs_fall();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    #1;
    check("mid_rst_tx_dv", {31'h0, tx_dv}, 32'h0);
    check("mid_rst_tx_byte", {24'h0, tx_byte}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    check("mid_rst_level", {28'h0, level}, 32'h0);
    m_fifo.delete();
    m_ovf    = 1'b0;
    m_idx    = 0;
    last_hdr = 8'h00;
    exp_q.push_back(8'h00);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    check("post_rst_level", {28'h0, level}, 32'd0);

    // Empty FIFO serves an all-zero frame and does not pop.
    cs_fall();
    send_frame(8'h00);
    cs_rise(1'b0, 32'h0);
    check("empty_frame_level", {28'h0, level}, 32'd0);

    tick(4);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
